cordic_seq: RTL and testbench
=============================

# cordic_seq

Iterative CORDIC rotation-mode sequencer feeding the single-iteration datapath `cordic_iter`. It accepts one angle per transaction over a valid/ready handshake, applies quadrant pre-rotation and gain pre-compensation, and steps X/Y/Z registers through `N_ITER` micro-rotations, one per clock. It then presents cos/sin on a registered output handshake to the downstream consumer.

## Interface
- `N_ITER`, default 24, number of micro-rotations; legal range 1..31.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: angle offered.
- `in_ready` output 1: block can accept an angle.
- `in_angle` input 32: signed angle, Q3.29 radians, legal range [-pi, +pi].
- `out_valid` output 1: result held on `out_cos`/`out_sin`.
- `out_ready` input 1: consumer accepts the result.
- `out_cos` output 32: signed, Q2.30 (1.0 = 0x40000000).
- `out_sin` output 32: signed, Q2.30.
- `busy` output 1: high in ITER or DONE.

## Operation
- The FSM has three states: IDLE, ITER and DONE.
- IDLE: `in_ready`=1.
  - On `in_valid & in_ready`, load `X`=K (0x26DD3B6A), `Y`=0, `Z`=pre-rotated angle, `iter`=0.
  - Set the `neg` flag per the pre-rotation rule.
  - Transition to ITER.
- Pre-rotation (macro enabled):
  - If angle > PI_2 (0x3243F6A9): Z = angle - PI (0x6487ED51), `neg`=1.
  - If angle < -PI_2: Z = angle + PI, `neg`=1.
  - Otherwise Z = angle, `neg`=0.
- ITER:
  - Each cycle, drive `cordic_iter` with X/Y/Z, `iter`, and `atan_val`=atan(2^-iter) in Q3.29.
  - Register its outputs back into X/Y/Z and increment `iter`.
  - When `iter`==N_ITER-1, register the final stage results into X/Y/Z as usual and transition to DONE.
  - In the same cycle, latch `out_cos` = `neg` ? -X_next : X_next and `out_sin` = `neg` ? -Y_next : Y_next.
- DONE: `out_valid`=1.
  - On `out_ready`, transition to IDLE and deassert `out_valid`.
  - An input is not accepted in the same cycle as output completion.
- Arithmetic:
  - All registers are 32-bit signed; wrap-around is never reached for legal inputs.
  - Negation of results uses two's complement; no saturation is needed because |result| ≤ 0x40000000 + tolerance.
- `in_angle` outside [-pi, pi] is undefined behaviour. The block does not flag it.

## Timing
- Reset values:
  - State = IDLE, `in_ready`=1, `out_valid`=0, `busy`=0.
  - `out_cos`=`out_sin`=0, and X/Y/Z/`iter`/`neg`=0.
- Latency: `out_valid` rises on the N_ITER-th rising edge after the accept edge (24 for the default).
- Throughput: one transaction per N_ITER+2 cycles when `out_ready` is held at 1.
- `in_ready` is combinational from state only; it never depends on `in_valid`.
- `out_cos`/`out_sin` are stable while `out_valid`=1 and `out_ready`=0 (stall), for any stall length.
- `rst_n` asserted mid-ITER or in DONE:
  - Return to reset values immediately, asynchronously.
  - The in-flight transaction is discarded, and no output handshake occurs after release.

## Configuration
- `CORDIC_QUAD_CORR_EN` defined: pre-rotation and output negation as described; full [-pi, pi] range is supported.
- Undefined:
  - Z loads `in_angle` directly and `neg` is tied 0, with no negation logic.
  - Legal input range shrinks to [-pi/2, pi/2]; other angles produce non-converged results.

## Structure
- Package `cordic_pkg` holds:
  - Q-format widths and the constants K, PI, PI_2.
  - The FSM state enum (IDLE, ITER, DONE).
  - The 32-entry atan table constant in Q3.29; entry 0 = 0x1921FB54.
- Sub-module `cordic_atan_rom`: combinational 5-bit index to 32-bit atan lookup.
- Instances: one `cordic_atan_rom` and one `cordic_iter`.

## Test plan
- Angle 0x00000000, `out_ready`=1:
  - `out_valid` rises 24 cycles after accept.
  - `out_cos`=0x40000000 ±256 LSB, `out_sin`=0 ±256.
- Angle 0x3243F6A9 (pi/2): cos=0 ±256, sin=0x40000000 ±256.
- Angle 0x6487ED51 (pi):
  - With the macro enabled: cos=0xC0000000 ±256 and sin=0 ±256.
  - With the macro undefined: the result differs from this, and no check is made.
- Angle 0x1921FB54 (pi/4):
  - `out_ready` held 0 for 10 cycles after `out_valid`; outputs hold 0x2D413CCD ±256 both, `in_ready`=0 throughout.
  - Handshake completes on release.
- `rst_n` pulsed low at iteration 10 with `in_valid` held high:
  - All outputs read reset values during reset.
  - After release, `in_ready`=1, a new accept occurs, and the result matches the new angle with no stale `out_valid`.
- Back-to-back stream of 4 angles (0, pi/2, -pi/2, -pi/4) with `out_ready`=1:
  - Accepts are spaced 26 cycles apart, and results arrive in order within tolerance.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and arctangent table for the iterative CORDIC sequencer.
// Angles are Q3.29 radians, cos/sin results are Q2.30.
package cordic_pkg;

  localparam int DATA_W     = 32;
  localparam int ITER_W     = 5;
  localparam int ANGLE_FRAC = 29;
  localparam int OUT_FRAC   = 30;

  // K is the inverse CORDIC gain in Q2.30; PI and PI_2 are Q3.29
  localparam logic signed [DATA_W-1:0] K    = 32'sh26DD3B6A;
  localparam logic signed [DATA_W-1:0] PI   = 32'sh6487ED51;
  localparam logic signed [DATA_W-1:0] PI_2 = 32'sh3243F6A9;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  // atan(2^-i) in Q3.29, rounded to nearest
  localparam logic [DATA_W-1:0] ATAN_TABLE [32] = '{
    32'h1921FB54, 32'h0ED63383, 32'h07D6DD7E, 32'h03FAB753,
    32'h01FF55BB, 32'h00FFEAAE, 32'h007FFD55, 32'h003FFFAB,
    32'h001FFFF5, 32'h000FFFFF, 32'h00080000, 32'h00040000,
    32'h00020000, 32'h00010000, 32'h00008000, 32'h00004000,
    32'h00002000, 32'h00001000, 32'h00000800, 32'h00000400,
    32'h00000200, 32'h00000100, 32'h00000080, 32'h00000040,
    32'h00000020, 32'h00000010, 32'h00000008, 32'h00000004,
    32'h00000002, 32'h00000001, 32'h00000000, 32'h00000000
  };

endpackage

// File: rtl/cordic_seq_if.sv
// Angle-in / cos-sin-out handshake bundle for cordic_seq.
// The sequencer connects to the slave modport and the angle producer/result consumer to the master modport.
interface cordic_seq_if;
  import cordic_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_angle;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_cos;
  logic [DATA_W-1:0] out_sin;
  logic              busy;

  modport master (
    output in_valid, in_angle, out_ready,
    input  in_ready, out_valid, out_cos, out_sin, busy
  );

  modport slave (
    input  in_valid, in_angle, out_ready,
    output in_ready, out_valid, out_cos, out_sin, busy
  );

endinterface

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup: index i returns atan(2^-i) in Q3.29.
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic [ITER_W-1:0] idx,
  output logic [DATA_W-1:0] atan_val
);

  assign atan_val = ATAN_TABLE[idx];

endmodule

// File: rtl/cordic_iter.sv
// One CORDIC rotation-mode micro-rotation; the sign of z picks the rotation direction.
module cordic_iter
  import cordic_pkg::*;
(
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] y,
  input  logic signed [DATA_W-1:0] z,
  input  logic        [ITER_W-1:0] shift,
  input  logic signed [DATA_W-1:0] atan_val,
  output logic signed [DATA_W-1:0] x_next,
  output logic signed [DATA_W-1:0] y_next,
  output logic signed [DATA_W-1:0] z_next
);

  logic signed [DATA_W-1:0] x_sh;
  logic signed [DATA_W-1:0] y_sh;

  assign x_sh = x >>> shift;
  assign y_sh = y >>> shift;

  always_comb begin
    if (z[DATA_W-1]) begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + atan_val;
    end else begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - atan_val;
    end
  end

endmodule

// File: rtl/cordic_seq.sv
// Iterative CORDIC rotation sequencer: one angle in, cos/sin out after N_ITER micro-rotations.
// Define CORDIC_QUAD_CORR_EN for quadrant pre-rotation (full [-pi, pi] input range).
//
// state | meaning
// IDLE  | in_ready high, waiting for an angle
// ITER  | one micro-rotation per clock, iter counts 0..N_ITER-1
// DONE  | result held with out_valid high until out_ready
module cordic_seq
  import cordic_pkg::*;
#(
  parameter int N_ITER = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  cordic_seq_if.slave  bus
);

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(N_ITER - 1);

  state_t                   state;
  logic signed [DATA_W-1:0] x;
  logic signed [DATA_W-1:0] y;
  logic signed [DATA_W-1:0] z;
  logic        [ITER_W-1:0] iter;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_cos;
  logic signed [DATA_W-1:0] out_sin;

  logic signed [DATA_W-1:0] angle;
  logic signed [DATA_W-1:0] z_load;
  logic signed [DATA_W-1:0] atan_val;
  logic signed [DATA_W-1:0] x_next;
  logic signed [DATA_W-1:0] y_next;
  logic signed [DATA_W-1:0] z_next;
  logic signed [DATA_W-1:0] cos_fin;
  logic signed [DATA_W-1:0] sin_fin;
  logic                     accept;

  assign angle  = $signed(bus.in_angle);
  assign accept = (state == IDLE) && bus.in_valid;

`ifdef CORDIC_QUAD_CORR_EN
  logic neg;
  logic neg_load;

  // Angles beyond +-pi/2 are folded by pi; the result is then negated on the way out
  always_comb begin
    z_load   = angle;
    neg_load = 1'b0;
    if (angle > PI_2) begin
      z_load   = angle - PI;
      neg_load = 1'b1;
    end else if (angle < -PI_2) begin
      z_load   = angle + PI;
      neg_load = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg <= 1'b0;
    end else if (accept) begin
      neg <= neg_load;
    end
  end

  assign cos_fin = neg ? -x_next : x_next;
  assign sin_fin = neg ? -y_next : y_next;
`else
  assign z_load  = angle;
  assign cos_fin = x_next;
  assign sin_fin = y_next;
`endif

  cordic_atan_rom u_atan_rom (
    .idx      (iter),
    .atan_val (atan_val)
  );

  cordic_iter u_iter (
    .x        (x),
    .y        (y),
    .z        (z),
    .shift    (iter),
    .atan_val (atan_val),
    .x_next   (x_next),
    .y_next   (y_next),
    .z_next   (z_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      iter      <= '0;
      out_valid <= 1'b0;
      out_cos   <= '0;
      out_sin   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x     <= K;
            y     <= '0;
            z     <= z_load;
            iter  <= '0;
            state <= ITER;
          end
        end
        ITER: begin
          x    <= x_next;
          y    <= y_next;
          z    <= z_next;
          iter <= iter + 1'b1;
          if (iter == LAST_ITER) begin
            out_cos   <= cos_fin;
            out_sin   <= sin_fin;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid;
  assign bus.out_cos   = out_cos;
  assign bus.out_sin   = out_sin;

endmodule

// File: tb/tb_cordic_seq.sv
// Scoreboard bench for cordic_seq: directed and random angles against a real-valued cos/sin model.
module tb_cordic_seq;

  localparam int      TOL     = 256;
  localparam int      LATENCY = 24;
  localparam int      A_PI_2  = 843314857;   // round(pi/2 * 2^29)
  localparam int      A_PI    = 1686629713;  // round(pi * 2^29)

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cordic_seq_if bus();

  cordic_seq #(.N_ITER(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  logic rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cos_e;
    int          sin_e;
    int unsigned acc;
  } exp_t;

  exp_t sb[$];

  task automatic chk_eq(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_tol(input string name, input int act, input int req);
    longint d;
    checks++;
    d = longint'(act) - longint'(req);
    if (d < 0) d = -d;
    if (d > TOL) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h +-%0d (t=%0t)", name, act, req, TOL, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  function automatic int q30(input real v);
    return int'(v * 1073741824.0);
  endfunction

  task automatic push_exp(input logic [31:0] a, input int unsigned acc);
    exp_t e;
    int   ai;
    real  r;
    ai = a;
    r = real'(ai) / 536870912.0;
    e.cos_e = q30($cos(r));
    e.sin_e = q30($sin(r));
    e.acc   = acc;
    sb.push_back(e);
  endtask

  // Offer an angle from a negedge; returns the posedge cycle at which it is accepted
  task automatic send(input logic [31:0] a, output int unsigned acc);
    int n;
    n = 0;
    acc = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_angle = a;
    while (!bus.in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      fail_now("accept_timeout", "in_ready never rose");
    end else begin
      acc = cyc + 1;
      push_exp(a, acc);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) fail_now("drain_timeout", "expected results never arrived");
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 bus.out_ready = v;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_eq({tag, "_in_ready"}, bus.in_ready, 1);
    chk_eq({tag, "_out_valid"}, bus.out_valid, 0);
    chk_eq({tag, "_busy"}, bus.busy, 0);
    chk_eq({tag, "_out_cos"}, bus.out_cos, 0);
    chk_eq({tag, "_out_sin"}, bus.out_sin, 0);
  endtask

  // Monitor: pops the scoreboard on every completed output handshake
  initial begin
    logic        prev_v;
    int unsigned rise;
    exp_t        e;
    prev_v = 1'b0;
    rise = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (bus.out_valid && !prev_v) rise = cyc;
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            fail_now("unexpected_result", "out_valid with no outstanding angle");
          end else begin
            e = sb.pop_front();
            chk_tol("result_cos", bus.out_cos, e.cos_e);
            chk_tol("result_sin", bus.out_sin, e.sin_e);
            chk_eq("latency", longint'(rise) - longint'(e.acc), LATENCY);
          end
        end
        prev_v = bus.out_valid;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int unsigned acc;
    int unsigned accs[4];
    logic [31:0] stream[4];
    logic [31:0] c0, s0;
    int n;
    longint v;

    bus.in_valid  = 1'b0;
    bus.in_angle  = '0;
    bus.out_ready = 1'b1;

    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed angles
    send(32'h00000000, acc);
    drain(200);
    send(32'h3243F6A9, acc);
    drain(200);
`ifdef CORDIC_QUAD_CORR_EN
    send(32'h6487ED51, acc);
    drain(200);
`endif

    // Output stall at pi/4
    set_ready(1'b0);
    send(32'h1921FB54, acc);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      fail_now("stall_wait", "out_valid never rose");
    end else begin
      c0 = bus.out_cos;
      s0 = bus.out_sin;
      chk_tol("stall_cos_val", c0, 32'h2D413CCD);
      chk_tol("stall_sin_val", s0, 32'h2D413CCD);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chk_eq("stall_out_valid", bus.out_valid, 1);
        chk_eq("stall_in_ready", bus.in_ready, 0);
        chk_eq("stall_cos_hold", bus.out_cos, c0);
        chk_eq("stall_sin_hold", bus.out_sin, s0);
      end
    end
    set_ready(1'b1);
    drain(200);

    // Reset mid-iteration, in_valid held high throughout
    send(32'h0C90FDAA, acc);
    repeat (9) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_angle = 32'hE6DE04AC;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midreset");
    sb.delete();
    @(negedge clk);
    chk_reset_vals("midreset_hold");
    rst_n = 1'b1;
    push_exp(32'hE6DE04AC, cyc + 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    drain(200);

    // Back-to-back stream
    stream[0] = 32'h00000000;
    stream[1] = 32'h3243F6A9;
    stream[2] = 32'hCDBC0957;
    stream[3] = 32'hE6DE04AC;
    for (int i = 0; i < 4; i++) send(stream[i], accs[i]);
    for (int i = 1; i < 4; i++) chk_eq("stream_spacing", longint'(accs[i]) - longint'(accs[i-1]), 26);
    drain(200);

    // Random angles with random consumer back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
`ifdef CORDIC_QUAD_CORR_EN
      v = longint'($urandom_range(0, 2 * A_PI)) - A_PI;
`else
      v = longint'($urandom_range(0, 2 * A_PI_2)) - A_PI_2;
`endif
      send(32'(v), acc);
    end
    drain(4000);
    rand_rdy = 1'b0;
    set_ready(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
